// File: rtl/adc_ctrl_pkg.sv
// Shared types and helpers for the ADC control blocks: FSM state encoding
// and a constant-foldable clog2 for sizing ID fields.
package adc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_load_count_down.sv
// Loadable down-counter that stops at zero; load has priority over decrement.
module sync_load_count_down #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (!reset_n)                     count <= '0;
    else if (load)                    count <= load_val;
    else if (dec && (count != '0))    count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/countdown_timer_arbiter.sv
// One shared delay timer, handed out round-robin to NUM_REQ requesters;
// the owner gets a grant pulse on load and a done pulse on expiry.
module countdown_timer_arbiter
  import adc_ctrl_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int COUNT_WIDTH = 16,
  localparam int ID_W        = clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_count,
  input  logic [NUM_REQ-1:0]             cancel,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [ID_W-1:0]                active_id,
  output logic [COUNT_WIDTH-1:0]         count_val
);

  state_e          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] next_ptr;
  logic            found;
  logic            zero;
  logic            cancel_hit;
  logic            load;
  logic            dec;

  // Rotating-priority search: first set req bit at or above rr_ptr, wrapping.
  always_comb begin : arb
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  assign next_ptr   = (int'(active_id) == NUM_REQ - 1) ? '0 : active_id + 1'b1;
  assign cancel_hit = cancel[active_id];
  assign load       = (state == IDLE) && found;
  // Expiry outranks cancel, so a cancel arriving at zero still lets done fire.
  assign dec        = (state == COUNT) && !zero && !cancel_hit;

  sync_load_count_down #(
    .WIDTH (COUNT_WIDTH)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (req_count[pick*COUNT_WIDTH +: COUNT_WIDTH]),
    .dec      (dec),
    .count    (count_val),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      active_id <= '0;
      rr_ptr    <= '0;
    end else begin
      grant <= '0;
      done  <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            active_id   <= pick;
            grant[pick] <= 1'b1;
            busy        <= 1'b1;
            state       <= COUNT;
          end
        end
        COUNT: begin
          if (zero) begin
            done[active_id] <= 1'b1;
            state           <= DONE;
          end else if (cancel_hit) begin
            rr_ptr <= next_ptr;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        DONE: begin
          rr_ptr <= next_ptr;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_arbiter.sv
// Directed bench: stimulus pushes expected grant/done events; a negedge
// monitor pops and checks id, order and cycle spacing.
module tb_countdown_timer_arbiter;

  localparam int NR = 4;
  localparam int CW = 16;
  localparam int IW = 2;

  logic               clk;
  logic               reset_n;
  logic [NR-1:0]      req;
  logic [NR*CW-1:0]   req_count;
  logic [NR-1:0]      cancel;
  logic [NR-1:0]      grant;
  logic [NR-1:0]      done;
  logic               busy;
  logic [IW-1:0]      active_id;
  logic [CW-1:0]      count_val;

  countdown_timer_arbiter #(.NUM_REQ(NR), .COUNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_count (req_count),
    .cancel    (cancel),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .active_id (active_id),
    .count_val (count_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int id;
    int lat;   // 0 = spacing not checked
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_chk  = 0;
  int  n_pass = 0;
  int  cyc    = 0;
  int  last_grant_cyc = 0;
  int  last_done_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push(input bit d, input int id, input int lat);
    ev_t e;
    e.is_done = d;
    e.id      = id;
    e.lat     = lat;
    exp_q.push_back(e);
  endtask

  task automatic set_cnt(input int id, input int v);
    req_count[id*CW +: CW] = CW'(v);
  endtask

  // Monitor: every grant/done pulse must match the head of the queue.
  always @(negedge clk) begin
    if (grant != '0) begin
      if (exp_q.size() == 0) chk("spurious_grant", int'(grant), 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("grant_order", int'(mon_e.is_done), 0);
        chk("grant_id", int'(grant), 1 << mon_e.id);
        if (mon_e.lat > 0) chk("grant_gap", cyc - last_done_cyc, mon_e.lat);
      end
      last_grant_cyc = cyc;
    end
    if (done != '0) begin
      if (exp_q.size() == 0) chk("spurious_done", int'(done), 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("done_order", int'(mon_e.is_done), 1);
        chk("done_id", int'(done), 1 << mon_e.id);
        if (mon_e.lat > 0) chk("done_latency", cyc - last_grant_cyc, mon_e.lat);
      end
      last_done_cyc = cyc;
    end
  end

  task automatic wait_grant(input int id);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (grant[id]) begin
        seen    = 1'b1;
        req[id] = 1'b0;
      end
    end
    if (!seen) chk("grant_timeout", int'(grant), 1 << id);
  endtask

  task automatic wait_done(input int id);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done[id]) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", int'(done), 1 << id);
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    if (!seen) chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_count(input int v);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (int'(count_val) == v) seen = 1'b1;
    end
    if (!seen) chk("count_timeout", int'(count_val), v);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_grant"},     int'(grant),     0);
    chk({tag, "_done"},      int'(done),      0);
    chk({tag, "_busy"},      int'(busy),      0);
    chk({tag, "_active_id"}, int'(active_id), 0);
    chk({tag, "_count_val"}, int'(count_val), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req       = '0;
    cancel    = '0;
    req_count = '0;
    reset_n   = 1'b0;
    @(negedge clk);
    do_reset();

    // 1: single requester, N=5 -> count 5..0, done 6 cycles after grant
    set_cnt(1, 5);
    push(1'b0, 1, 0);
    push(1'b1, 1, 6);
    req[1] = 1'b1;
    wait_grant(1);
    chk("t1_count_load", int'(count_val), 5);
    chk("t1_active_id", int'(active_id), 1);
    chk("t1_busy", int'(busy), 1);
    set_cnt(1, 100);  // changing after grant must not disturb the job
    for (int v = 4; v >= 0; v--) begin
      @(negedge clk);
      chk("t1_count_val", int'(count_val), v);
    end
    wait_idle();

    // 2: all request, two rounds, strict 0..3 order after reset
    do_reset();
    for (int i = 0; i < NR; i++) set_cnt(i, 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) begin
        push(1'b0, i, (r == 0 && i == 0) ? 0 : 2);
        push(1'b1, i, 3);
      end
    req = '1;
    for (int i = 0; i < NR; i++) wait_grant(i);
    req = '1;  // owner 3 re-requests while busy: must not be re-served early
    for (int i = 0; i < NR; i++) wait_grant(i);
    wait_idle();

    // 3: zero delay, done right after grant; immediate re-request
    set_cnt(2, 0);
    push(1'b0, 2, 0);
    push(1'b1, 2, 1);
    push(1'b0, 2, 2);
    push(1'b1, 2, 1);
    req[2] = 1'b1;
    wait_grant(2);
    wait_done(2);
    req[2] = 1'b1;
    wait_grant(2);
    wait_idle();

    // 4: owner 2 cancelled at 4, non-owner cancel ignored, 3 next
    set_cnt(2, 10);
    set_cnt(3, 1);
    push(1'b0, 2, 0);
    push(1'b0, 3, 0);
    push(1'b1, 3, 2);
    req[2] = 1'b1;
    wait_grant(2);
    req[3] = 1'b1;
    wait_count(5);
    cancel = 4'b0001;
    @(negedge clk);
    chk("t4_nonowner_cancel", int'(count_val), 4);
    cancel = 4'b0100;
    @(negedge clk);
    cancel = '0;
    chk("t4_cancel_busy", int'(busy), 0);
    wait_grant(3);
    wait_idle();

    // 5: cancel in the count==0 cycle loses to done
    set_cnt(1, 3);
    push(1'b0, 1, 0);
    push(1'b1, 1, 4);
    req[1] = 1'b1;
    wait_grant(1);
    wait_count(0);
    cancel = 4'b0010;
    @(negedge clk);
    cancel = '0;
    chk("t5_done_wins", int'(done), 4'b0010);
    wait_idle();

    // 6: reset mid-COUNT discards the job, pending req served afterwards
    set_cnt(0, 8);
    push(1'b0, 0, 0);
    req[0] = 1'b1;
    wait_grant(0);
    repeat (3) @(negedge clk);
    set_cnt(3, 1);
    req[3]  = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("t6_midjob_reset");
    push(1'b0, 3, 0);
    push(1'b1, 3, 2);
    reset_n = 1'b1;
    wait_grant(3);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
